// File: rtl/inm_encoder.sv
// Searches for an 8-bit immediate plus 4-bit even rotation that reproduces a 32-bit constant.
// Optional feature macro: INM_INVERT_EN adds a second pass over ~value (MVN form).
module inm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [7:0]  inm,
  output logic [3:0]  rotate,
  output logic        inverted
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned ROT_W  = 4;
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(15);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRCH     = 2'd1,
    SRCH_INV = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ROT_W-1:0]    r_q, r_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [IMM_W-1:0]    inm_q, inm_d;
  logic [ROT_W-1:0]    rot_q, rot_d;

  logic [DATA_W-1:0]   op_c;
  logic [DATA_W-1:0]   t_c;
  logic                hit_c;

  // Rotate left by 2*r using a doubled word so no zero-width shift corner exists.
  function automatic logic [DATA_W-1:0] rotl2(input logic [DATA_W-1:0] v,
                                               input logic [ROT_W-1:0]  r);
    logic [2*DATA_W-1:0] dbl;
    dbl = {v, v} << {r, 1'b0};
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

`ifdef INM_INVERT_EN
  logic inv_q, inv_d;
  assign inverted = inv_q;
  always_comb op_c = (state_q == SRCH_INV) ? ~val_q : val_q;
`else
  assign inverted = 1'b0;
  always_comb op_c = val_q;
`endif

  always_comb begin
    t_c   = rotl2(op_c, r_q);
    hit_c = (t_c[DATA_W-1:IMM_W] == '0);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    inm_d   = inm_q;
    rot_d   = rot_q;
`ifdef INM_INVERT_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          r_d     = '0;
          busy_d  = 1'b1;
          state_d = SRCH;
        end
      end
      SRCH: begin
        if (hit_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          inm_d   = t_c[IMM_W-1:0];
          rot_d   = r_q;
`ifdef INM_INVERT_EN
          inv_d   = 1'b0;
`endif
        end else if (r_q == ROT_LAST) begin
`ifdef INM_INVERT_EN
          state_d = SRCH_INV;
          r_d     = '0;
`else
          state_d = IDLE;
          r_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b0;
          inm_d   = '0;
          rot_d   = '0;
`endif
        end else begin
          r_d = r_q + ROT_W'(1);
        end
      end
`ifdef INM_INVERT_EN
      SRCH_INV: begin
        if (hit_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          inm_d   = t_c[IMM_W-1:0];
          rot_d   = r_q;
          inv_d   = 1'b1;
        end else if (r_q == ROT_LAST) begin
          state_d = IDLE;
          r_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b0;
          inm_d   = '0;
          rot_d   = '0;
          inv_d   = 1'b0;
        end else begin
          r_d = r_q + ROT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Synchronous active-low reset; reset also discards a coincident start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      inm_q   <= '0;
      rot_q   <= '0;
`ifdef INM_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      inm_q   <= inm_d;
      rot_q   <= rot_d;
`ifdef INM_INVERT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;
  assign inm    = inm_q;
  assign rotate = rot_q;

endmodule
